// File: rtl/xbuf_pkg.sv
// xbuf_pkg: shared state enum and counter-width helper for the X operand buffer.
package xbuf_pkg;
    typedef enum logic {FILL = 1'b0, FULL = 1'b1} xbuf_state_e;
    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/xbuf_lane.sv
// xbuf_lane: one DEPTH x DATA_W lane; load and rotate both shift entries up,
// differing only in what enters entry 0 (new operand vs. the current head).
module xbuf_lane #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load_en,
    input  logic              rot_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head
);
    logic [DEPTH-1:0][DATA_W-1:0] r_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_q <= '0;
        else if (clr) r_q <= '0;
        else if (load_en || rot_en) r_q <= {r_q[DEPTH-2:0], load_en ? din : r_q[DEPTH-1]};
    end
    assign head = r_q[DEPTH-1];
endmodule

// File: rtl/x_operand_buffer.sv
// x_operand_buffer: round-robin fill of LANES rotating lanes feeding the PE array X side.
// Optional synchronous clear input enabled by defining XBUF_FLUSH_EN.
module x_operand_buffer
    import xbuf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int LANES  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       shift,
    input  logic                       reload,
    output logic [LANES*DATA_W-1:0]    lane_out,
    output logic                       load_done,
    output logic [$clog2(DEPTH)-1:0]   rot_idx,
    output logic                       rot_wrap
`ifdef XBUF_FLUSH_EN
    ,
    input  logic                       flush
`endif
);
    localparam int PW = cw(LANES);
    localparam int DW = cw(DEPTH);
    localparam int RW = $clog2(DEPTH);
    xbuf_state_e   r_state;
    logic [PW-1:0] r_lane_ptr;
    logic [DW-1:0] r_depth_cnt;
    logic [RW-1:0] r_rot_idx;
    logic          r_rot_wrap;
    logic          w_flush, w_accept, w_rot, w_rot_last;
`ifdef XBUF_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif
    assign in_ready   = (r_state == FILL);
    assign load_done  = (r_state == FULL);
    assign rot_idx    = r_rot_idx;
    assign rot_wrap   = r_rot_wrap;
    // reload and flush suppress both load and rotation of storage
    assign w_accept   = in_valid && in_ready && !reload && !w_flush;
    assign w_rot      = load_done && shift && !reload && !w_flush;
    assign w_rot_last = (r_rot_idx == RW'(DEPTH - 1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= FILL;
            r_lane_ptr  <= '0;
            r_depth_cnt <= '0;
            r_rot_idx   <= '0;
            r_rot_wrap  <= 1'b0;
        end else if (w_flush || reload) begin
            r_state     <= FILL;
            r_lane_ptr  <= '0;
            r_depth_cnt <= '0;
            r_rot_idx   <= '0;
            r_rot_wrap  <= 1'b0;
        end else begin
            r_rot_wrap <= w_rot && w_rot_last;
            if (w_rot) r_rot_idx <= w_rot_last ? '0 : r_rot_idx + 1'b1;
            if (w_accept) begin
                if (r_lane_ptr == PW'(LANES - 1)) begin
                    r_lane_ptr <= '0;
                    if (r_depth_cnt == DW'(DEPTH - 1)) begin
                        r_depth_cnt <= '0;
                        r_state     <= FULL;
                    end else begin
                        r_depth_cnt <= r_depth_cnt + 1'b1;
                    end
                end else begin
                    r_lane_ptr <= r_lane_ptr + 1'b1;
                end
            end
        end
    end
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        xbuf_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clr     (w_flush),
            .load_en (w_accept && (r_lane_ptr == PW'(g))),
            .rot_en  (w_rot),
            .din     (in_data),
            .head    (lane_out[g*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_x_operand_buffer.sv
// tb_x_operand_buffer: directed/table-driven checks of the default build plus a LANES=1, DEPTH=2 instance.
module tb_x_operand_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, shift = 1'b0, reload = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, load_done, rot_wrap;
    logic [31:0] lane_out;
    logic [2:0]  rot_idx;
    logic        v1 = 1'b0, s1 = 1'b0, rl1 = 1'b0;
    logic [7:0]  d1 = '0;
    logic        ready1, done1, wrap1;
    logic [7:0]  lo1;
    logic [0:0]  ri1;
`ifdef XBUF_FLUSH_EN
    logic        flush = 1'b0;
`endif
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    x_operand_buffer #(.DATA_W(8), .DEPTH(8), .LANES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .shift(shift), .reload(reload), .lane_out(lane_out), .load_done(load_done),
        .rot_idx(rot_idx), .rot_wrap(rot_wrap)
`ifdef XBUF_FLUSH_EN
        , .flush(flush)
`endif
    );

    x_operand_buffer #(.DATA_W(8), .DEPTH(2), .LANES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ready1), .in_data(d1),
        .shift(s1), .reload(rl1), .lane_out(lo1), .load_done(done1),
        .rot_idx(ri1), .rot_wrap(wrap1)
`ifdef XBUF_FLUSH_EN
        , .flush(1'b0)
`endif
    );

    typedef struct {
        logic        shift;
        logic        reload;
        logic [31:0] lo;
        logic [2:0]  idx;
        logic        wrap;
        logic        ready;
        logic        done;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fill(input logic [7:0] base, input int n, input bit toggle, input bit shf);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = base + 8'(i); shift = shf;
            @(posedge clk);
            if (toggle && i < n - 1) begin
                @(negedge clk); in_valid = 1'b0;
                @(posedge clk);
            end
        end
        @(negedge clk); in_valid = 1'b0; shift = 1'b0;
    endtask

    task automatic cyc(input logic shf, input logic rl);
        @(negedge clk); shift = shf; reload = rl;
        @(posedge clk); #1;
        @(negedge clk); shift = 1'b0; reload = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h08070605, 3'd1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 32'h0C0B0A09, 3'd2, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 32'h100F0E0D, 3'd3, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 32'h14131211, 3'd4, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 32'h18171615, 3'd5, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 32'h1C1B1A19, 3'd6, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 32'h201F1E1D, 3'd7, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 32'h04030201, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 32'h04030201, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{1'b1, 1'b1, 32'h04030201, 3'd0, 1'b0, 1'b1, 1'b0};

        #12;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_idx", 32'(rot_idx), 32'd0);
        chk("rst_wrap", 32'(rot_wrap), 32'd0);
        chk("rst_lane_out", lane_out, 32'h0);
        @(negedge clk); rst = 1'b1;

        fill(8'h01, 31, 1'b0, 1'b0);
        chk("ready_after_31", 32'(in_ready), 32'd1);
        chk("done_after_31", 32'(load_done), 32'd0);
        fill(8'h20, 1, 1'b0, 1'b0);
        chk("ready_after_32", 32'(in_ready), 32'd0);
        chk("done_after_32", 32'(load_done), 32'd1);
        chk("fill_lane_out", lane_out, 32'h04030201);

        // rotation sequence, then reload+shift in FULL
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); shift = tbl[i].shift; reload = tbl[i].reload;
            @(posedge clk); #1;
            chk($sformatf("v%0d_lane_out", i), lane_out, tbl[i].lo);
            chk($sformatf("v%0d_rot_idx", i), 32'(rot_idx), 32'(tbl[i].idx));
            chk($sformatf("v%0d_rot_wrap", i), 32'(rot_wrap), 32'(tbl[i].wrap));
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(tbl[i].ready));
            chk($sformatf("v%0d_done", i), 32'(load_done), 32'(tbl[i].done));
        end
        @(negedge clk); shift = 1'b0; reload = 1'b0;

        fill(8'h21, 32, 1'b1, 1'b1);
        chk("toggle_lane_out", lane_out, 32'h24232221);
        chk("toggle_rot_idx", 32'(rot_idx), 32'd0);
        chk("toggle_done", 32'(load_done), 32'd1);

        cyc(1'b0, 1'b1);
        fill(8'h90, 10, 1'b0, 1'b0);
        @(negedge clk); reload = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        @(posedge clk);
        @(negedge clk); reload = 1'b0; in_valid = 1'b0;
        fill(8'h41, 32, 1'b0, 1'b0);
        chk("reload_lane_out", lane_out, 32'h44434241);
        chk("reload_done", 32'(load_done), 32'd1);

        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("two_shift_lane_out", lane_out, 32'h4C4B4A49);
        chk("two_shift_idx", 32'(rot_idx), 32'd2);
        rst = 1'b0; #1;
        chk("async_rst_lane_out", lane_out, 32'h0);
        chk("async_rst_idx", 32'(rot_idx), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        chk("async_rst_done", 32'(load_done), 32'd0);
        @(negedge clk); rst = 1'b1;

`ifdef XBUF_FLUSH_EN
        fill(8'h01, 32, 1'b0, 1'b0);
        chk("pre_flush_done", 32'(load_done), 32'd1);
        @(negedge clk); flush = 1'b1; shift = 1'b1;
        @(posedge clk); #1;
        chk("flush_lane_out", lane_out, 32'h0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        chk("flush_idx", 32'(rot_idx), 32'd0);
        @(negedge clk); flush = 1'b0; shift = 1'b0;
`endif

        @(negedge clk); v1 = 1'b1; d1 = 8'h0A;
        @(negedge clk); d1 = 8'h0B;
        @(negedge clk); v1 = 1'b0;
        chk("small_done", 32'(done1), 32'd1);
        chk("small_fill", 32'(lo1), 32'h0A);
        s1 = 1'b1;
        @(posedge clk); #1;
        chk("small_shift1", 32'(lo1), 32'h0B);
        chk("small_idx1", 32'(ri1), 32'd1);
        chk("small_wrap1", 32'(wrap1), 32'd0);
        @(posedge clk); #1;
        chk("small_shift2", 32'(lo1), 32'h0A);
        chk("small_idx2", 32'(ri1), 32'd0);
        chk("small_wrap2", 32'(wrap1), 32'd1);
        s1 = 1'b0;
        @(posedge clk); #1;
        chk("small_wrap_pulse", 32'(wrap1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
